// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the ID/EX hazard controller.
// RegDst/PCSrc codes, FSM states and instruction field ranges.
package hazard_ctrl_pkg;

  localparam logic [1:0] RD_RT    = 2'd0;
  localparam logic [1:0] RD_RD    = 2'd1;
  localparam logic [1:0] RD_RA    = 2'd2;
  localparam logic [1:0] PCSRC_JR = 2'd2;

  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;
  localparam int RD_HI = 15;
  localparam int RD_LO = 11;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_RA   = 5'd31;

  typedef enum logic {
    ST_RUN,
    ST_JR_WAIT
  } state_t;

  // Destination register written by the EX instruction.
  function automatic logic [4:0] dst_sel(
    input logic [1:0]  regdst,
    input logic [31:0] ir
  );
    logic [4:0] d;
    d = REG_ZERO;
    case (regdst)
      RD_RT:   d = ir[RT_HI:RT_LO];
      RD_RD:   d = ir[RD_HI:RD_LO];
      RD_RA:   d = REG_RA;
      default: d = REG_ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle seen by the hazard controller.
// master = datapath, slave = hazard_ctrl.
interface hazard_ctrl_if;
  logic [31:0] IR_IF_ID;
  logic [1:0]  PCSrc_ID;
  logic [31:0] IR_ID_EX;
  logic [1:0]  RegDst_ID_EX;
  logic        RegWrite_ID_EX;
  logic        MemRead_ID_EX;
  logic        Branch_taken_EX;
  logic        PC_Write;
  logic        IF_ID_Write;
  logic        IF_ID_Flush;
  logic        ID_EX_Flush;

  modport master (
    output IR_IF_ID, PCSrc_ID, IR_ID_EX,
    output RegDst_ID_EX, RegWrite_ID_EX,
    output MemRead_ID_EX, Branch_taken_EX,
    input  PC_Write, IF_ID_Write,
    input  IF_ID_Flush, ID_EX_Flush
  );

  modport slave (
    input  IR_IF_ID, PCSrc_ID, IR_ID_EX,
    input  RegDst_ID_EX, RegWrite_ID_EX,
    input  MemRead_ID_EX, Branch_taken_EX,
    output PC_Write, IF_ID_Write,
    output IF_ID_Flush, ID_EX_Flush
  );
endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // count events, hold once all-ones
  always_ff @(posedge clk) begin
    if (reset)
      cnt <= '0;
    else if (inc && !(&cnt))
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for the ID/EX register.
// Load-use, jr-operand and taken-branch handling.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W          = 32,
  parameter int JR_LOAD_STALLS = 2
) (
  input  logic             clk,
  input  logic             reset,
  hazard_ctrl_if.slave     hz,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] JR_INIT =
    2'(JR_LOAD_STALLS - 1);

  state_t     state, state_n;
  logic [1:0] jr_cnt, jr_cnt_n;

  logic [4:0] rs_id, rt_id, dst_ex;
  logic       hit_rs, hit_rt;
  logic       lu, jh;

  logic pc_we, ifid_we, ifid_fl, idex_fl;

  logic unused_bits;
  assign unused_bits = ^{hz.IR_IF_ID[15:0],
                         hz.IR_ID_EX[31:21],
                         hz.IR_ID_EX[10:0]};

  assign rs_id  = hz.IR_IF_ID[RS_HI:RS_LO];
  assign rt_id  = hz.IR_IF_ID[RT_HI:RT_LO];
  assign dst_ex = dst_sel(hz.RegDst_ID_EX,
                          hz.IR_ID_EX);

  assign hit_rs = hz.RegWrite_ID_EX &&
                  dst_ex != REG_ZERO &&
                  dst_ex == rs_id;
  assign hit_rt = hz.RegWrite_ID_EX &&
                  dst_ex != REG_ZERO &&
                  dst_ex == rt_id;

  assign lu = hz.MemRead_ID_EX && (hit_rs || hit_rt);
  assign jh = hz.PCSrc_ID == PCSRC_JR && hit_rs;

  // FSM state and jr countdown register
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_RUN;
      jr_cnt <= 2'd0;
    end else begin
      state  <= state_n;
      jr_cnt <= jr_cnt_n;
    end
  end

  // next state and stall/flush enables
  always_comb begin
    state_n  = state;
    jr_cnt_n = jr_cnt;
    pc_we    = 1'b1;
    ifid_we  = 1'b1;
    ifid_fl  = 1'b0;
    idex_fl  = 1'b0;
    if (reset) begin
      state_n  = ST_RUN;
      jr_cnt_n = 2'd0;
    end else if (hz.Branch_taken_EX) begin
      ifid_fl  = 1'b1;
      idex_fl  = 1'b1;
      state_n  = ST_RUN;
      jr_cnt_n = 2'd0;
    end else if (state == ST_JR_WAIT) begin
      pc_we   = 1'b0;
      ifid_we = 1'b0;
      idex_fl = 1'b1;
      if (jr_cnt == 2'd1) begin
        state_n  = ST_RUN;
        jr_cnt_n = 2'd0;
      end else begin
        jr_cnt_n = jr_cnt - 2'd1;
      end
    end else if (jh && hz.MemRead_ID_EX) begin
      pc_we   = 1'b0;
      ifid_we = 1'b0;
      idex_fl = 1'b1;
      if (JR_LOAD_STALLS > 1) begin
        state_n  = ST_JR_WAIT;
        jr_cnt_n = JR_INIT;
      end
    end else if (jh || lu) begin
      pc_we   = 1'b0;
      ifid_we = 1'b0;
      idex_fl = 1'b1;
    end
  end

  assign hz.PC_Write    = pc_we;
  assign hz.IF_ID_Write = ifid_we;
  assign hz.IF_ID_Flush = ifid_fl;
  assign hz.ID_EX_Flush = idex_fl;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (!pc_we),
    .cnt   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (hz.Branch_taken_EX),
    .cnt   (flush_cnt)
  );

endmodule
